slave_resp_router: RTL and testbench

- Slave-side response stage of the log interconnect, one instance per memory bank.
- Records the one-hot master ID of every accepted request and delays it through a fixed-latency pipeline matched to the bank.
- When the bank returns data, it asserts the response valid toward the originating master only and broadcasts the read data.
- Its per-master valid/rdata outputs feed the slave-indexed inputs of each master's response fan-in tree.

---
 rtl/slave_resp_router_if.sv | 33 +++
 rtl/slave_resp_router.sv | 77 +++++++
 tb/tb_slave_resp_router.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/slave_resp_router_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | slave_resp_router_if : request/response bundle at one bank port  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface slave_resp_router_if #(
    parameter int N_MASTER    = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
);
    localparam int CNT_WIDTH = $clog2(MEM_LATENCY + 1);

    logic                  data_req_i;
    logic                  data_gnt_i;
    logic [N_MASTER-1:0]   data_ID_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  err_clr_i;
    logic [N_MASTER-1:0]   data_r_valid_o;
    logic [DATA_WIDTH-1:0] data_r_rdata_o;
    logic [CNT_WIDTH-1:0]  outstanding_o;
    logic                  err_o;

    modport slave (
        input  data_req_i, data_gnt_i, data_ID_i, mem_rdata_i, err_clr_i,
        output data_r_valid_o, data_r_rdata_o, outstanding_o, err_o
    );

    modport master (
        output data_req_i, data_gnt_i, data_ID_i, mem_rdata_i, err_clr_i,
        input  data_r_valid_o, data_r_rdata_o, outstanding_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/slave_resp_router.sv
`default_nettype none
// +------------------------------------------------------------------+
// | slave_resp_router : routes bank read data back to the one-hot    |
// | master that issued the request, after a fixed bank latency.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module slave_resp_router #(
    parameter int N_MASTER    = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    slave_resp_router_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    logic                 w_accept;
    logic                 w_id_ok;
    logic                 w_inc;
    logic                 w_dec;
    logic [MEM_LATENCY-1:0] r_vld;
    logic [N_MASTER-1:0]  r_id [MEM_LATENCY];
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_err;

    assign w_accept = bus.data_req_i & bus.data_gnt_i;
    assign w_id_ok  = $onehot(bus.data_ID_i);
    assign w_inc    = w_accept & w_id_ok;
    assign w_dec    = r_vld[MEM_LATENCY-1];

    // Fixed-latency ID pipeline; a malformed ID enters as a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                r_id[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_inc;
            r_id[0]  <= bus.data_ID_i;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_id[i]  <= r_id[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_inc && !w_dec) begin
            r_cnt <= r_cnt + c_cnt_one;
        end else if (!w_inc && w_dec) begin
            r_cnt <= r_cnt - c_cnt_one;
        end
    end

    // A new bad ID takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_id_ok) begin
            r_err <= 1'b1;
        end else if (bus.err_clr_i) begin
            r_err <= 1'b0;
        end
    end

    assign bus.data_r_valid_o = r_vld[MEM_LATENCY-1] ? r_id[MEM_LATENCY-1] : '0;
    assign bus.data_r_rdata_o = r_vld[MEM_LATENCY-1] ? bus.mem_rdata_i : '0;
    assign bus.outstanding_o  = r_cnt;
    assign bus.err_o          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_slave_resp_router.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_slave_resp_router : directed bench, one DUT per latency 1..4  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_slave_resp_router;
    logic        clk;
    logic        rst_n;
    logic        req;
    logic        gnt;
    logic [3:0]  id;
    logic [31:0] md;
    logic        clr;

    logic [3:0]  vld_o [4];
    logic [31:0] rd_o  [4];
    logic [2:0]  out_o [4];
    logic        err_a [4];

    logic [3:0]  hist [4];
    logic        m_err;
    int          n_chk;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_lat
        slave_resp_router_if #(.N_MASTER(4), .DATA_WIDTH(32), .MEM_LATENCY(g + 1)) bus ();

        slave_resp_router #(.N_MASTER(4), .DATA_WIDTH(32), .MEM_LATENCY(g + 1)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign bus.data_req_i  = req;
        assign bus.data_gnt_i  = gnt;
        assign bus.data_ID_i   = id;
        assign bus.mem_rdata_i = md;
        assign bus.err_clr_i   = clr;
        assign vld_o[g] = bus.data_r_valid_o;
        assign rd_o[g]  = bus.data_r_rdata_o;
        assign out_o[g] = 3'(bus.outstanding_o);
        assign err_a[g] = bus.err_o;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs of latency L: response = ID accepted L edges ago,
    // outstanding = accepted IDs among the last L edges.
    task automatic check_model();
        for (int l = 0; l < 4; l++) begin
            logic [3:0] ev;
            logic [2:0] ec;
            ev = hist[l];
            ec = 3'd0;
            for (int j = 0; j <= l; j++) begin
                if (hist[j] != 4'd0) ec++;
            end
            check($sformatf("L%0d_valid", l + 1), 64'(vld_o[l]), 64'(ev));
            check($sformatf("L%0d_rdata", l + 1), 64'(rd_o[l]), (ev != 4'd0) ? 64'(md) : 64'd0);
            check($sformatf("L%0d_outstanding", l + 1), 64'(out_o[l]), 64'(ec));
            check($sformatf("L%0d_err", l + 1), 64'(err_a[l]), 64'(m_err));
        end
    endtask

    task automatic cyc(input logic rq, input logic gt, input logic [3:0] idv,
                       input logic [31:0] mdv, input logic cl, input logic rs);
        req = rq; gnt = gt; id = idv; md = mdv; clr = cl; rst_n = rs;
        @(posedge clk);
        if (!rs) begin
            for (int i = 0; i < 4; i++) hist[i] = 4'd0;
            m_err = 1'b0;
        end else begin
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = (rq && gt && $countones(idv) == 1) ? idv : 4'd0;
            if (rq && gt && $countones(idv) != 1) m_err = 1'b1;
            else if (cl) m_err = 1'b0;
        end
        @(negedge clk);
        check_model();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        m_err = 1'b0;
        for (int i = 0; i < 4; i++) hist[i] = 4'd0;

        // Reset, including a valid accept presented during reset
        cyc(1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 4'b0001, 32'h1234, 1'b1, 1'b0);
        check("rst_valid", 64'(vld_o[0]), 64'd0);
        check("rst_out", 64'(out_o[3]), 64'd0);
        cyc(1'b0, 1'b0, 4'b0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check("rst_rdata", 64'(rd_o[0]), 64'd0);

        // Single accept of master 2
        cyc(1'b1, 1'b1, 4'b0100, 32'hDEADBEEF, 1'b0, 1'b1);
        check("l1_valid", 64'(vld_o[0]), 64'h4);
        check("l1_rdata", 64'(rd_o[0]), 64'hDEADBEEF);
        check("l1_out_1", 64'(out_o[0]), 64'd1);
        cyc(1'b0, 1'b0, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b1);
        check("l1_out_0", 64'(out_o[0]), 64'd0);
        check("l1_valid_gone", 64'(vld_o[0]), 64'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'b0000, 32'hA5A5A5A5, 1'b0, 1'b1);

        // Back-to-back accepts from three masters
        cyc(1'b1, 1'b1, 4'b0001, 32'hA5A5A5A5, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 4'b0010, 32'hA5A5A5A5, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 4'b1000, 32'h0000_0013, 1'b0, 1'b1);
        check("l3_peak", 64'(out_o[2]), 64'd3);
        check("l3_first", 64'(vld_o[2]), 64'h1);
        cyc(1'b0, 1'b0, 4'b0000, 32'h0000_0014, 1'b0, 1'b1);
        check("l3_second", 64'(vld_o[2]), 64'h2);
        cyc(1'b0, 1'b1, 4'b0100, 32'h0000_0015, 1'b0, 1'b1);
        check("l3_third", 64'(vld_o[2]), 64'h8);
        check("l3_rdata", 64'(rd_o[2]), 64'h15);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 4'b0100, 32'h5A5A5A5A, 1'b0, 1'b1);

        // Request held without grant, then one grant
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 4'b0010, 32'hCAFE0000, 1'b0, 1'b1);
        check("nogrant_out", 64'(out_o[3]), 64'd0);
        cyc(1'b1, 1'b1, 4'b0010, 32'hCAFE0001, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 4'b0010, 32'hCAFE0002, 1'b0, 1'b1);
        check("grant_l2", 64'(vld_o[1]), 64'h2);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'b0000, 32'hCAFE0003, 1'b0, 1'b1);

        // Malformed IDs and sticky error
        cyc(1'b1, 1'b1, 4'b0110, 32'h0BAD0001, 1'b0, 1'b1);
        check("bad_err", 64'(err_a[0]), 64'd1);
        check("bad_valid", 64'(vld_o[0]), 64'd0);
        cyc(1'b1, 1'b1, 4'b0000, 32'h0BAD0002, 1'b0, 1'b1);
        check("bad0_out", 64'(out_o[3]), 64'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'b0000, 32'h0BAD0003, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 4'b0000, 32'h0, 1'b1, 1'b1);
        check("clr_err", 64'(err_a[1]), 64'd0);
        cyc(1'b1, 1'b1, 4'b1100, 32'h0, 1'b1, 1'b1);
        check("set_wins", 64'(err_a[2]), 64'd1);
        cyc(1'b0, 1'b0, 4'b0000, 32'h0, 1'b1, 1'b1);
        check("clr_again", 64'(err_a[3]), 64'd0);

        // Reset while a response is in flight
        cyc(1'b1, 1'b1, 4'b0001, 32'h7777_0000, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 4'b0000, 32'h7777_0001, 1'b0, 1'b0);
        check("midrst_valid", 64'(vld_o[1]), 64'd0);
        check("midrst_out", 64'(out_o[1]), 64'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'b0000, 32'h7777_0002, 1'b0, 1'b1);

        // Continuous random one-hot traffic
        for (int i = 0; i < 50; i++) begin
            cyc(1'b1, 1'b1, 4'b0001 << $urandom_range(0, 3), $urandom, 1'b0, 1'b1);
            if (i >= 3) check("stream_out", 64'(out_o[3]), 64'd4);
        end
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 4'b0000, $urandom, 1'b0, 1'b1);
        check("drain_out", 64'(out_o[3]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
